// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control: a Moore FSM that sequences fetch, decode, execute,
// memory and write-back, and drives datapath mux selects and write enables.
module multicycle_control #(
    parameter logic MEM_HANDSHAKE = 1'b1,
    parameter logic SUPPORT_BNE   = 1'b1,
    parameter logic EXC_ENABLE    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       LuOp,
    output logic       Exception,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] PCSource,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_LWWB     = 4'd4,
        S_MEMWRITE = 4'd5,
        S_REXEC    = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_JREG     = 4'd10,
        S_IEXEC    = 4'd11,
        S_IWB      = 4'd12,
        S_EXC      = 4'd13
    } state_t;

    state_t cur, nxt, illegal;
    logic   ready;

    assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign illegal = EXC_ENABLE ? S_EXC : S_FETCH;
    assign state   = reset ? cur : 4'd0;

    function automatic logic legal_r(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: legal_r = 1'b1;
            default:                           legal_r = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt         = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        Exception   = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 3'b000;
        // Reset forces every strobe and select low, even mid-instruction.
        if (reset) begin
            case (cur)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = ready;
                    PCWrite = ready;
                    nxt     = ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    case (OpCode)
                        6'h23, 6'h2B: nxt = S_MEMADDR;
                        6'h00: begin
                            if (Funct == 6'h08 || Funct == 6'h09) nxt = S_JREG;
                            else if (legal_r(Funct))              nxt = S_REXEC;
                            else                                  nxt = illegal;
                        end
                        6'h04:        nxt = S_BRANCH;
                        6'h05:        nxt = SUPPORT_BNE ? S_BRANCH : illegal;
                        6'h02, 6'h03: nxt = S_JUMP;
                        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F: nxt = S_IEXEC;
                        default:      nxt = illegal;
                    endcase
                end
                S_MEMADDR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                    nxt     = (OpCode == 6'h2B) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    nxt     = ready ? S_LWWB : S_MEMREAD;
                end
                S_LWWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEMWRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    nxt      = ready ? S_FETCH : S_MEMWRITE;
                end
                S_REXEC: begin
                    ALUSrcA = (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03) ? 2'b10 : 2'b01;
                    ALUOp   = 2'b10;
                    nxt     = S_RWB;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                end
                S_BRANCH: begin
                    ALUSrcA     = 2'b01;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 3'b001;
                    BranchNe    = (OpCode == 6'h05);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 3'b010;
                    if (OpCode == 6'h03) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                S_JREG: begin
                    PCWrite  = 1'b1;
                    PCSource = 3'b011;
                    if (Funct == 6'h09) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                end
                S_IEXEC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                    ExtOp   = (OpCode != 6'h0C);
                    LuOp    = (OpCode == 6'h0F);
                    nxt     = S_IWB;
                end
                S_IWB: begin
                    RegWrite = 1'b1;
                end
                S_EXC: begin
                    PCWrite   = 1'b1;
                    PCSource  = 3'b100;
                    Exception = 1'b1;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three instances with different
// parameter sets, each cycle checked against hand-written state/control vectors.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       mem_ready;

    // Control vector layout: strobes [23:13], RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource.
    logic [23:0] c1, c2, c3;
    logic [3:0]  s1, s2, s3;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    function automatic logic [23:0] fld(input logic [1:0] rd, input logic [1:0] mtr,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] aop, input logic [2:0] pcs);
        return {11'b0, rd, mtr, sa, sb, aop, pcs};
    endfunction

    localparam logic [23:0] PCW = 24'h800000;
    localparam logic [23:0] PCC = 24'h400000;
    localparam logic [23:0] BNE = 24'h200000;
    localparam logic [23:0] IOD = 24'h100000;
    localparam logic [23:0] MR  = 24'h080000;
    localparam logic [23:0] MW  = 24'h040000;
    localparam logic [23:0] IRW = 24'h020000;
    localparam logic [23:0] RW  = 24'h010000;
    localparam logic [23:0] EXT = 24'h008000;
    localparam logic [23:0] LU  = 24'h004000;
    localparam logic [23:0] EXC = 24'h002000;

    localparam logic [23:0] V_F1    = MR | IRW | PCW | fld(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0);
    localparam logic [23:0] V_F0    = MR | fld(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0);
    localparam logic [23:0] V_DEC   = EXT | fld(2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0);
    localparam logic [23:0] V_MADDR = EXT | fld(2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 3'd0);
    localparam logic [23:0] V_MRD   = MR | IOD;
    localparam logic [23:0] V_LWWB  = RW | fld(2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0);
    localparam logic [23:0] V_MWR   = MW | IOD;
    localparam logic [23:0] V_SLL   = fld(2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0);
    localparam logic [23:0] V_RWB   = RW | fld(2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
    localparam logic [23:0] V_JALR  = PCW | RW | fld(2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 3'd3);
    localparam logic [23:0] V_BNE   = PCC | BNE | fld(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 3'd1);
    localparam logic [23:0] V_EXC   = PCW | EXC | fld(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd4);
    localparam logic [23:0] V_ANDI  = fld(2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 3'd0);
    localparam logic [23:0] V_LUI   = EXT | LU | fld(2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 3'd0);
    localparam logic [23:0] V_IWB   = RW;

    multicycle_control dut1 (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(c1[23]), .PCWriteCond(c1[22]), .BranchNe(c1[21]), .IorD(c1[20]),
        .MemRead(c1[19]), .MemWrite(c1[18]), .IRWrite(c1[17]), .RegWrite(c1[16]),
        .ExtOp(c1[15]), .LuOp(c1[14]), .Exception(c1[13]), .RegDst(c1[12:11]),
        .MemtoReg(c1[10:9]), .ALUSrcA(c1[8:7]), .ALUSrcB(c1[6:5]), .ALUOp(c1[4:3]),
        .PCSource(c1[2:0]), .state(s1)
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b1), .SUPPORT_BNE(1'b0), .EXC_ENABLE(1'b1)) dut2 (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(c2[23]), .PCWriteCond(c2[22]), .BranchNe(c2[21]), .IorD(c2[20]),
        .MemRead(c2[19]), .MemWrite(c2[18]), .IRWrite(c2[17]), .RegWrite(c2[16]),
        .ExtOp(c2[15]), .LuOp(c2[14]), .Exception(c2[13]), .RegDst(c2[12:11]),
        .MemtoReg(c2[10:9]), .ALUSrcA(c2[8:7]), .ALUSrcB(c2[6:5]), .ALUOp(c2[4:3]),
        .PCSource(c2[2:0]), .state(s2)
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b0), .SUPPORT_BNE(1'b1), .EXC_ENABLE(1'b0)) dut3 (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(c3[23]), .PCWriteCond(c3[22]), .BranchNe(c3[21]), .IorD(c3[20]),
        .MemRead(c3[19]), .MemWrite(c3[18]), .IRWrite(c3[17]), .RegWrite(c3[16]),
        .ExtOp(c3[15]), .LuOp(c3[14]), .Exception(c3[13]), .RegDst(c3[12:11]),
        .MemtoReg(c3[10:9]), .ALUSrcA(c3[8:7]), .ALUSrcB(c3[6:5]), .ALUOp(c3[4:3]),
        .PCSource(c3[2:0]), .state(s3)
    );

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed state=%0d ctl=%h, expected state=%0d ctl=%h",
                   tag, obs[27:24], obs[23:0], exp[27:24], exp[23:0]);
        end
    endtask

    // One clock cycle: sample instance `sel` at the falling edge, then step past the rising edge.
    task automatic step(input string tag, input int sel, input logic [3:0] es, input logic [23:0] ev);
        @(negedge clk);
        case (sel)
            2:       chk(tag, {s2, c2}, {es, ev});
            3:       chk(tag, {s3, c3}, {es, ev});
            default: chk(tag, {s1, c1}, {es, ev});
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        OpCode    = 6'h00;
        Funct     = 6'h00;
        mem_ready = 1'b0;
        step("reset0", 1, 4'd0, 24'h0);
        step("reset1", 1, 4'd0, 24'h0);
        reset = 1'b1;

        // sw with two wait cycles in MEMWRITE
        OpCode = 6'h2B; mem_ready = 1'b1;
        step("sw_fetch", 1, 4'd0, V_F1);
        step("sw_dec",   1, 4'd1, V_DEC);
        step("sw_addr",  1, 4'd2, V_MADDR);
        mem_ready = 1'b0;
        step("sw_wait0", 1, 4'd5, V_MWR);
        step("sw_wait1", 1, 4'd5, V_MWR);
        mem_ready = 1'b1;
        step("sw_done",  1, 4'd5, V_MWR);

        // reset while stalled in MEMWRITE
        step("rs_fetch", 1, 4'd0, V_F1);
        step("rs_dec",   1, 4'd1, V_DEC);
        step("rs_addr",  1, 4'd2, V_MADDR);
        mem_ready = 1'b0;
        step("rs_mw",    1, 4'd5, V_MWR);
        reset = 1'b0;
        step("rs_hold0", 1, 4'd0, 24'h0);
        step("rs_hold1", 1, 4'd0, 24'h0);
        step("rs_hold2", 1, 4'd0, 24'h0);
        reset = 1'b1;
        step("rs_fetch_wait", 1, 4'd0, V_F0);
        mem_ready = 1'b1;

        // lw, zero wait states
        OpCode = 6'h23;
        step("lw_fetch", 1, 4'd0, V_F1);
        step("lw_dec",   1, 4'd1, V_DEC);
        step("lw_addr",  1, 4'd2, V_MADDR);
        step("lw_read",  1, 4'd3, V_MRD);
        step("lw_wb",    1, 4'd4, V_LWWB);

        // sll then jalr
        OpCode = 6'h00; Funct = 6'h00;
        step("sll_fetch", 1, 4'd0, V_F1);
        step("sll_dec",   1, 4'd1, V_DEC);
        step("sll_exec",  1, 4'd6, V_SLL);
        step("sll_wb",    1, 4'd7, V_RWB);
        Funct = 6'h09;
        step("jalr_fetch", 1, 4'd0, V_F1);
        step("jalr_dec",   1, 4'd1, V_DEC);
        step("jalr_jreg",  1, 4'd10, V_JALR);

        // bne with branch support
        OpCode = 6'h05; Funct = 6'h00;
        step("bne_fetch",  1, 4'd0, V_F1);
        step("bne_dec",    1, 4'd1, V_DEC);
        step("bne_branch", 1, 4'd8, V_BNE);

        // andi, lui
        OpCode = 6'h0C;
        step("andi_fetch", 1, 4'd0, V_F1);
        step("andi_dec",   1, 4'd1, V_DEC);
        step("andi_exec",  1, 4'd11, V_ANDI);
        step("andi_wb",    1, 4'd12, V_IWB);
        OpCode = 6'h0F;
        step("lui_fetch", 1, 4'd0, V_F1);
        step("lui_dec",   1, 4'd1, V_DEC);
        step("lui_exec",  1, 4'd11, V_LUI);
        step("lui_wb",    1, 4'd12, V_IWB);

        // illegal opcode with exceptions enabled
        OpCode = 6'h3F;
        step("ill_fetch", 1, 4'd0, V_F1);
        step("ill_dec",   1, 4'd1, V_DEC);
        step("ill_exc",   1, 4'd13, V_EXC);
        step("ill_back",  1, 4'd0, V_F1);

        // bne without branch support traps
        reset = 1'b0;
        step("p2_reset", 2, 4'd0, 24'h0);
        reset = 1'b1; OpCode = 6'h05;
        step("nobne_fetch", 2, 4'd0, V_F1);
        step("nobne_dec",   2, 4'd1, V_DEC);
        step("nobne_exc",   2, 4'd13, V_EXC);

        // illegal opcode as NOP, memory handshake ignored
        reset = 1'b0;
        step("p3_reset", 3, 4'd0, 24'h0);
        reset = 1'b1; OpCode = 6'h3F; mem_ready = 1'b0;
        step("nop_fetch", 3, 4'd0, V_F1);
        step("nop_dec",   3, 4'd1, V_DEC);
        step("nop_back",  3, 4'd0, V_F1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit: replaces per-instruction combinational decode with a Moore state machine that sequences fetch, decode, execute, memory and write-back across several cycles over a shared ALU and a single memory port. Sits between the instruction register (OpCode/Funct), the memory port (mem_ready handshake) and the datapath muxes/write enables. Adds bne, jalr, memory wait-states and an illegal-opcode exception.

## Interface
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
- SUPPORT_BNE, 1, 1: opcode 6'h05 is branch-not-equal; 0: 6'h05 is illegal
- EXC_ENABLE, 1, 1: illegal opcode/funct enters EXC; 0: treated as NOP, returns to FETCH
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- OpCode  in  6  IR[31:26], held stable by datapath after FETCH
- Funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes access this cycle
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp, Exception  out  1 each
- RegDst  out  2  00 rt, 01 rd, 10 $ra
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  2  00 PC, 01 rs, 10 shamt
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 decode Funct, 11 decode OpCode
- PCSource  out  3  000 ALU, 001 ALUOut, 010 jump target, 011 rs, 100 exception vector
- state  out  4  current state (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, LWWB 4, MEMWRITE 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, JREG 10, IEXEC 11, IWB 12, EXC 13. Codes 14/15 -> FETCH next cycle, all strobes 0.
- Outputs are Moore decode of state (plus mem_ready gating); unlisted outputs are 0.
- FETCH: MemRead, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=000; IRWrite=PCWrite=mem_ready. Stay until mem_ready.
- DECODE: ALUSrcA=00, ALUSrcB=11, ALUOp=00, ExtOp=1 (branch target to ALUOut). Next: 23h/2Bh->MEMADDR; 00h with Funct 08h/09h->JREG, other legal funct->REXEC; 04h (and 05h if SUPPORT_BNE)->BRANCH; 02h/03h->JUMP; 08h,09h,0Ah,0Bh,0Ch,0Fh->IEXEC; else EXC (or FETCH if EXC_ENABLE=0).
- Legal R funct: 00,02,03,08,09,20,21,22,23,24,25,26,27,2A,2B (hex).
- MEMADDR: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=00 -> MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: MemRead, IorD=1; wait mem_ready -> LWWB. LWWB: RegWrite, RegDst=00, MemtoReg=01.
- MEMWRITE: MemWrite, IorD=1; wait mem_ready -> FETCH. MemWrite held high until the mem_ready cycle inclusive.
- REXEC: ALUSrcA=10 if Funct in {00,02,03} else 01; ALUSrcB=00; ALUOp=10 -> RWB. RWB: RegWrite, RegDst=01, MemtoReg=00.
- IEXEC: ALUSrcA=01, ALUSrcB=10, ALUOp=11, ExtOp=0 for 0Ch else 1, LuOp=1 for 0Fh -> IWB. IWB: RegWrite, RegDst=00, MemtoReg=00.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=001, BranchNe=(OpCode==05h).
- JUMP: PCWrite, PCSource=010; OpCode 03h also RegWrite, RegDst=10, MemtoReg=10.
- JREG: PCWrite, PCSource=011; Funct 09h also RegWrite, RegDst=01, MemtoReg=10.
- EXC: PCWrite, PCSource=100, Exception=1.
- BRANCH, JUMP, JREG, EXC, RWB, IWB, LWWB -> FETCH unconditionally.

## Timing
- Reset: reset==0 at a rising edge sets state=FETCH; while reset==0 every output strobe and mux select is 0 (state output reads 0). Reset mid-instruction aborts it; no RegWrite/MemWrite/PCWrite issued during or after the reset cycle until FETCH resumes.
- First FETCH strobe is the cycle after reset deasserts.
- Cycles per instruction with zero wait: lw 5, sw/R/I-type 4, beq/bne/j/jal/jr/jalr/EXC 3. Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle (MEM_HANDSHAKE=1).
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Write strobes (RegWrite, PCWrite, MemWrite, IRWrite) are single-state pulses; no strobe spans a state change.

## Test plan
- Reset low 3 cycles in MEMWRITE with mem_ready=0 -> state=0, MemWrite=0 throughout, FETCH MemRead=1 on first cycle after release.
- lw (23h), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in state 4 with MemtoReg=01.
- sw (2Bh), mem_ready low 2 cycles in MEMWRITE -> MemWrite high 3 cycles, then FETCH; 6 cycles total.
- R sll (00h/00h) then jalr (00h/09h) -> REXEC ALUSrcA=10; jalr: states 0,1,10 with PCSource=011, RegWrite=1, MemtoReg=10.
- bne (05h) with SUPPORT_BNE=1 -> BRANCH BranchNe=1, PCWriteCond=1; with SUPPORT_BNE=0 -> EXC, Exception=1, PCSource=100.
- Opcode 3Fh with EXC_ENABLE=0 -> 0,1,0, no write strobes; andi (0Ch) -> IEXEC ExtOp=0; lui (0Fh) -> LuOp=1, IWB RegWrite.
